game_ctrl: RTL and testbench

Top-level game sequencer for the shooting game. It replaces the ad-hoc life and game-over/game-clear logic with one clocked state machine. It consumes the hit strobe from the bullet block, the boss HP from the boss block and a start key from the PS/2 input path. It drives the life shift register, round-reset pulse, invulnerability window and end-of-game flags consumed by plane, enm, bullet, myb and vga_RGB.

---
 rtl/game_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Game sequencer: lives, invulnerability window, round reset and
//            game-over / game-clear flags for the shooting game.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int INV_TICKS   = 150,
    parameter int BLINK_TICKS = 10,
    parameter int HOLD_TICKS  = 200
) (
    input  logic       clk,
    input  logic       switch,
    input  logic       tick,
    input  logic       start,
    input  logic       shot,
    input  logic [9:0] bosshp,
    output logic [2:0] life,
    output logic       playing,
    output logic       invuln,
    output logic       blink,
    output logic       gameover,
    output logic       gameclear,
    output logic       round_rst,
    output logic [2:0] state
);

    localparam logic [7:0] c_INV_LOAD   = 8'(INV_TICKS - 1);
    localparam logic [7:0] c_HOLD_LOAD  = 8'(HOLD_TICKS - 1);
    localparam logic [3:0] c_BLINK_LOAD = 4'(BLINK_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_INVULN = 3'd2,
        S_OVER   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_bcnt, w_bcnt_nxt;
    logic [2:0] r_life, w_life_nxt;
    logic       r_blink, w_blink_nxt;
    logic       r_armed, w_armed_nxt;
    logic       w_round_rst_nxt;
    logic       r_start_q, r_shot_q;
    logic       r_playing, r_invuln, r_gameover, r_gameclear, r_round_rst;

    logic       w_start_e, w_shot_e, w_boss_dead;
    logic [2:0] w_life_shifted;

    assign w_start_e      = start & ~r_start_q;
    assign w_shot_e       = shot & ~r_shot_q;
    assign w_boss_dead    = (bosshp == 10'd0);
    assign w_life_shifted = {r_life[1:0], 1'b0};

    // State register; the _q registers reset high so held levels never fire.
    always_ff @(posedge clk or posedge switch) begin
        if (switch) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b1;
            r_shot_q  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            r_shot_q  <= shot;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bcnt_nxt      = r_bcnt;
        w_life_nxt      = r_life;
        w_blink_nxt     = r_blink;
        w_armed_nxt     = r_armed;
        w_round_rst_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_life_nxt  = 3'b111;
                w_blink_nxt = 1'b1;
                w_cnt_nxt   = 8'd0;
                if (w_start_e) begin
                    w_state_nxt     = S_PLAY;
                    w_round_rst_nxt = 1'b1;
                    w_armed_nxt     = 1'b0;
                end
            end

            S_PLAY: begin
                if (r_armed && w_boss_dead) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end else if (w_shot_e) begin
                    // A coinciding tick is deliberately dropped here.
                    w_life_nxt = w_life_shifted;
                    if (w_life_shifted == 3'b000) begin
                        w_state_nxt = S_OVER;
                        w_cnt_nxt   = c_HOLD_LOAD;
                    end else begin
                        w_state_nxt = S_INVULN;
                        w_cnt_nxt   = c_INV_LOAD;
                        w_bcnt_nxt  = c_BLINK_LOAD;
                        w_blink_nxt = 1'b0;
                    end
                end else if (tick) begin
                    w_armed_nxt = 1'b1;
                end
            end

            S_INVULN: begin
                if (r_armed && w_boss_dead) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = c_HOLD_LOAD;
                    w_blink_nxt = 1'b1;
                end else if (tick) begin
                    w_armed_nxt = 1'b1;
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = S_PLAY;
                        w_blink_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                        if (r_bcnt == 4'd0) begin
                            w_blink_nxt = ~r_blink;
                            w_bcnt_nxt  = c_BLINK_LOAD;
                        end else begin
                            w_bcnt_nxt = r_bcnt - 4'd1;
                        end
                    end
                end
            end

            S_OVER, S_CLEAR: begin
                if (w_start_e && (r_cnt == 8'd0)) begin
                    w_state_nxt = S_IDLE;
                    w_life_nxt  = 3'b111;
                    w_blink_nxt = 1'b1;
                end else if (tick && (r_cnt != 8'd0)) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_life_nxt  = 3'b111;
                w_blink_nxt = 1'b1;
            end
        endcase
    end

    // Datapath and flags are registered from the next state so every output
    // changes on the same edge as the state register.
    always_ff @(posedge clk or posedge switch) begin
        if (switch) begin
            r_cnt       <= 8'd0;
            r_bcnt      <= 4'd0;
            r_life      <= 3'b111;
            r_blink     <= 1'b1;
            r_armed     <= 1'b0;
            r_round_rst <= 1'b0;
            r_playing   <= 1'b0;
            r_invuln    <= 1'b0;
            r_gameover  <= 1'b0;
            r_gameclear <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_life      <= w_life_nxt;
            r_blink     <= w_blink_nxt;
            r_armed     <= w_armed_nxt;
            r_round_rst <= w_round_rst_nxt;
            r_playing   <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_INVULN);
            r_invuln    <= (w_state_nxt == S_INVULN);
            r_gameover  <= (w_state_nxt == S_OVER);
            r_gameclear <= (w_state_nxt == S_CLEAR);
        end
    end

    assign life      = r_life;
    assign playing   = r_playing;
    assign invuln    = r_invuln;
    assign blink     = r_blink;
    assign gameover  = r_gameover;
    assign gameclear = r_gameclear;
    assign round_rst = r_round_rst;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Directed self-checking bench for game_ctrl (small timer values).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       switch = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       shot = 1'b0;
    logic [9:0] bosshp = 10'd100;
    logic [2:0] life;
    logic       playing, invuln, blink, gameover, gameclear, round_rst;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    game_ctrl #(
        .INV_TICKS  (4),
        .BLINK_TICKS(2),
        .HOLD_TICKS (3)
    ) u_dut (
        .clk      (clk),
        .switch   (switch),
        .tick     (tick),
        .start    (start),
        .shot     (shot),
        .bosshp   (bosshp),
        .life     (life),
        .playing  (playing),
        .invuln   (invuln),
        .blink    (blink),
        .gameover (gameover),
        .gameclear(gameclear),
        .round_rst(round_rst),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick period: four idle clocks, then a one-clock tick strobe.
    task automatic tick_once();
        repeat (4) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".state"}, state, 0);
        chk({tag, ".life"}, life, 7);
        chk({tag, ".playing"}, playing, 0);
        chk({tag, ".invuln"}, invuln, 0);
        chk({tag, ".blink"}, blink, 1);
        chk({tag, ".gameover"}, gameover, 0);
        chk({tag, ".gameclear"}, gameclear, 0);
        chk({tag, ".round_rst"}, round_rst, 0);
    endtask

    // Hit in PLAY, then run out the 4-tick invulnerability window.
    task automatic hit_and_recover(input string tag, input int exp_life);
        int exp_blink [4] = '{0, 1, 1, 1};
        int exp_state [4] = '{2, 2, 2, 1};
        shot = 1'b1;
        step();
        chk({tag, ".life"}, life, exp_life);
        chk({tag, ".state"}, state, 2);
        chk({tag, ".invuln"}, invuln, 1);
        chk({tag, ".blink0"}, blink, 0);
        // Keep shot high, then re-pulse it: neither may cost a life.
        step();
        shot = 1'b0;
        step();
        shot = 1'b1;
        step();
        shot = 1'b0;
        chk({tag, ".life_ignored"}, life, exp_life);
        for (int i = 0; i < 4; i++) begin
            tick_once();
            chk($sformatf("%s.blink_t%0d", tag, i + 1), blink, exp_blink[i]);
            chk($sformatf("%s.state_t%0d", tag, i + 1), state, exp_state[i]);
            chk($sformatf("%s.invuln_t%0d", tag, i + 1), invuln, (i < 3) ? 1 : 0);
        end
        chk({tag, ".life_end"}, life, exp_life);
    endtask

    initial begin
        // Reset
        repeat (3) step();
        check_reset_outputs("rst");
        switch = 1'b0;
        step();

        // Start: one-clock round_rst and PLAY on the next edge
        start = 1'b1;
        step();
        chk("start.round_rst", round_rst, 1);
        chk("start.state", state, 1);
        chk("start.life", life, 7);
        chk("start.playing", playing, 1);
        start = 1'b0;
        step();
        chk("start.round_rst_low", round_rst, 0);

        // Boss HP 0 before the first tick must not clear the round
        bosshp = 10'd0;
        step();
        step();
        chk("unarmed.state", state, 1);
        chk("unarmed.gameclear", gameclear, 0);
        bosshp = 10'd100;
        tick_once();

        hit_and_recover("hit1", 6);
        hit_and_recover("hit2", 4);

        // Last life
        shot = 1'b1;
        step();
        shot = 1'b0;
        chk("hit3.life", life, 0);
        chk("hit3.state", state, 3);
        chk("hit3.gameover", gameover, 1);
        chk("hit3.playing", playing, 0);

        // OVER hold: early starts ignored, accepted once cnt has reached 0
        start_pulse();
        chk("over.early0", state, 3);
        tick_once();
        start_pulse();
        chk("over.early1", state, 3);
        tick_once();
        tick_once();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("over.exit_state", state, 0);
        chk("over.exit_life", life, 7);
        chk("over.exit_gameover", gameover, 0);
        step();

        // Armed boss kill coinciding with a hit: CLEAR wins, life kept
        start_pulse();
        chk("clr.play", state, 1);
        tick_once();
        bosshp = 10'd0;
        shot = 1'b1;
        step();
        shot = 1'b0;
        bosshp = 10'd100;
        chk("clr.state", state, 4);
        chk("clr.gameclear", gameclear, 1);
        chk("clr.life", life, 7);
        chk("clr.playing", playing, 0);
        repeat (3) tick_once();
        start_pulse();
        chk("clr.exit_state", state, 0);
        chk("clr.exit_gameclear", gameclear, 0);

        // Asynchronous reset mid-INVULN with start held high
        start_pulse();
        shot = 1'b1;
        step();
        shot = 1'b0;
        chk("ar.invuln", state, 2);
        start = 1'b1;
        step();
        #2;
        switch = 1'b1;
        #1;
        check_reset_outputs("ar");
        step();
        step();
        switch = 1'b0;
        step();
        step();
        chk("ar.held_state", state, 0);
        chk("ar.held_round_rst", round_rst, 0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ar.restart_state", state, 1);
        chk("ar.restart_round_rst", round_rst, 1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
